// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch sequencer for a synchronous ROM: fetch, capture, hold for the consumer.
// Optional halt-opcode detection is enabled by defining ROM_FETCH_HALT_DETECT_EN.
module rom_fetch_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_instr_ready,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic              o_rom_enable,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_instr
);

    localparam int unsigned OPC_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              rom_en_q, rom_en_d;
    logic              is_halt_c;

`ifdef ROM_FETCH_HALT_DETECT_EN
    logic              halted_q, halted_d;

    assign is_halt_c = (instr_q[DATA_W-1 -: OPC_W] == {OPC_W{1'b1}});
    assign o_halted  = halted_q;
`else
    assign is_halt_c = 1'b0;
    assign o_halted  = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rom_addr_d = rom_addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        rom_en_d   = 1'b0;
`ifdef ROM_FETCH_HALT_DETECT_EN
        halted_d   = halted_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_jump) begin
                    pc_d = i_jump_addr;
                end
                if (i_run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                instr_d = i_rom_instr;
                valid_d = 1'b1;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (i_instr_ready) begin
                    valid_d = 1'b0;
                    // A jump on the handshake overrides halt detection
                    if (i_jump) begin
                        pc_d    = i_jump_addr;
                        state_d = i_run ? ST_FETCH : ST_IDLE;
                    end else if (is_halt_c) begin
                        state_d = ST_HALT;
`ifdef ROM_FETCH_HALT_DETECT_EN
                        halted_d = 1'b1;
`endif
                    end else begin
                        state_d = i_run ? ST_FETCH : ST_IDLE;
                    end
                end
            end

            ST_HALT: begin
                if (i_jump) begin
                    pc_d    = i_jump_addr;
                    state_d = ST_IDLE;
`ifdef ROM_FETCH_HALT_DETECT_EN
                    halted_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // ROM strobe is registered, so it is raised on entry into FETCH
        if (state_d == ST_FETCH) begin
            rom_en_d   = 1'b1;
            rom_addr_d = pc_d;
        end
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            rom_addr_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            rom_en_q   <= 1'b0;
`ifdef ROM_FETCH_HALT_DETECT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rom_addr_q <= rom_addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            rom_en_q   <= rom_en_d;
`ifdef ROM_FETCH_HALT_DETECT_EN
            halted_q   <= halted_d;
`endif
        end
    end

    assign o_pc          = pc_q;
    assign o_rom_addr    = rom_addr_q;
    assign o_rom_enable  = rom_en_q;
    assign o_instr       = instr_q;
    assign o_instr_valid = valid_q;

endmodule
